// File: rtl/ram_responder.sv
// Backing-memory responder for the cache-miss protocol: one request at a time, fixed LAT-clock access, one-cycle ack.
// Define RAM_RESP_ERR_EN to flag and suppress out-of-range accesses instead of wrapping the address modulo DEPTH.
module ram_responder #(
   parameter int d_width = 8,
   parameter int a_width = 8,
   parameter int DEPTH   = 16,
   parameter int LAT     = 2
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               enab,
   input  logic               rw,
   input  logic [a_width-1:0] Addr,
   input  logic [d_width-1:0] data_in,
   output logic [d_width-1:0] data_out,
   output logic               ack,
   output logic               busy,
   output logic               err,
   output logic [d_width-1:0] mem0,
   output logic [d_width-1:0] mem1,
   output logic [d_width-1:0] mem2,
   output logic [d_width-1:0] mem3,
   output logic [d_width-1:0] mem4,
   output logic [d_width-1:0] mem5,
   output logic [d_width-1:0] mem6,
   output logic [d_width-1:0] mem7
);

   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               rw_q, rw_d;
   logic [a_width-1:0] addr_q, addr_d;
   logic [d_width-1:0] wdata_q, wdata_d;
   logic [d_width-1:0] dout_q, dout_d;
   logic [d_width-1:0] mem_q [DEPTH];
   logic               mem_we;
   logic [IDX_W-1:0]   idx;
   logic               oor;

   assign idx = addr_q[IDX_W-1:0];

`ifdef RAM_RESP_ERR_EN
   assign oor = ({1'b0, addr_q} >= (a_width+1)'(DEPTH));
`else
   // Address wraps modulo DEPTH; the upper address bits are deliberately ignored.
   logic unused_addr;
   assign unused_addr = ^addr_q;
   assign oor = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rw_d    = rw_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      dout_d  = dout_q;
      mem_we  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (enab) begin
               state_d = WAIT;
               cnt_d   = 4'(LAT - 1);
               rw_d    = rw;
               addr_d  = Addr;
               wdata_d = data_in;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
               if (rw_q) mem_we = !oor;
               else      dout_d = oor ? '0 : mem_q[idx];
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
      end
   end

   // Request fields only matter while a request is in flight, so they carry no reset.
   always_ff @(posedge clk) begin
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (mem_we) begin
         mem_q[idx] <= wdata_q;
      end
   end

   assign data_out = dout_q;
   assign ack      = (state_q == RESP);
   assign busy     = (state_q != IDLE);
   assign err      = ack & oor;

   assign mem0 = mem_q[0];
   assign mem1 = mem_q[1];
   assign mem2 = mem_q[2];
   assign mem3 = mem_q[3];
   assign mem4 = mem_q[4];
   assign mem5 = mem_q[5];
   assign mem6 = mem_q[6];
   assign mem7 = mem_q[7];

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: randomized requests against an array model, plus a LAT=1 instance.
module tb_ram_responder;

   localparam int DEPTH = 16;
   localparam int LAT   = 2;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic       enab = 1'b0, rw = 1'b0;
   logic [7:0] Addr = '0, data_in = '0;
   logic [7:0] data_out;
   logic       ack, busy, err;
   logic [7:0] m0 [8];

   logic       e1 = 1'b0, rw1 = 1'b0;
   logic [7:0] a1 = '0, d1 = '0;
   logic [7:0] do1;
   logic       ack1, busy1, err1;
   logic [7:0] m1 [8];

   always #5 clk = ~clk;

   ram_responder #(.d_width(8), .a_width(8), .DEPTH(DEPTH), .LAT(LAT)) u_dut (
      .clk(clk), .clr(clr), .enab(enab), .rw(rw), .Addr(Addr), .data_in(data_in),
      .data_out(data_out), .ack(ack), .busy(busy), .err(err),
      .mem0(m0[0]), .mem1(m0[1]), .mem2(m0[2]), .mem3(m0[3]),
      .mem4(m0[4]), .mem5(m0[5]), .mem6(m0[6]), .mem7(m0[7]));

   ram_responder #(.d_width(8), .a_width(8), .DEPTH(DEPTH), .LAT(1)) u_lat1 (
      .clk(clk), .clr(clr), .enab(e1), .rw(rw1), .Addr(a1), .data_in(d1),
      .data_out(do1), .ack(ack1), .busy(busy1), .err(err1),
      .mem0(m1[0]), .mem1(m1[1]), .mem2(m1[2]), .mem3(m1[3]),
      .mem4(m1[4]), .mem5(m1[5]), .mem6(m1[6]), .mem7(m1[7]));

   typedef struct {
      int          acc;
      logic [7:0]  dout;
      logic        err;
      logic [63:0] mem;
   } exp_t;

   exp_t        sb[$];
   exp_t        head;
   logic [7:0]  mdl_mem [DEPTH];
   logic [7:0]  mdl_dout;
   logic [7:0]  vis_dout;
   logic        vis_err;
   logic [63:0] vis_mem;
   logic        exp_ack;
   int          cyc = 0;
   int          n_vec = 0;
   int          n_miss = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] window();
      logic [63:0] w;
      for (int k = 0; k < 8; k++) w[k*8 +: 8] = mdl_mem[k];
      return w;
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < DEPTH; k++) mdl_mem[k] = '0;
      mdl_dout = '0;
      vis_dout = '0;
      vis_err  = 1'b0;
      vis_mem  = '0;
      sb.delete();
   endfunction

   // Reference behaviour: each request maps to its final effect on memory/data_out.
   function automatic void model_issue(input logic w, input logic [7:0] a, input logic [7:0] d, input int acc);
      exp_t e;
      int   idx = int'(a) % DEPTH;
      logic bad = 1'b0;
`ifdef RAM_RESP_ERR_EN
      bad = (int'(a) >= DEPTH);
`endif
      if (w) begin
         if (!bad) mdl_mem[idx] = d;
      end else begin
         mdl_dout = bad ? 8'h00 : mdl_mem[idx];
      end
      e.acc  = acc;
      e.dout = mdl_dout;
      e.err  = bad;
      e.mem  = window();
      sb.push_back(e);
   endfunction

   always @(negedge clk) begin
      if (clr) begin
         exp_ack = 1'b0;
         if (sb.size() > 0) exp_ack = (cyc == sb[0].acc + LAT);
         chk("busy", 64'(busy), 64'(sb.size() > 0));
         chk("ack", 64'(ack), 64'(exp_ack));
         if (exp_ack) begin
            head     = sb.pop_front();
            vis_dout = head.dout;
            vis_err  = head.err;
            vis_mem  = head.mem;
         end
         chk("err", 64'(err), 64'(exp_ack & vis_err));
         chk("data_out", 64'(data_out), 64'(vis_dout));
         chk("mem0_7", {m0[7], m0[6], m0[5], m0[4], m0[3], m0[2], m0[1], m0[0]}, vis_mem);
      end
   end

   // mode 0: random junk on the inputs while in flight; mode 1: enab held, read of address 6.
   task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d, input int mode);
      @(negedge clk);
      enab = 1'b1; rw = w; Addr = a; data_in = d;
      @(posedge clk);
      #1;
      model_issue(w, a, d, cyc);
      for (int k = 0; k < LAT + 1; k++) begin
         @(negedge clk);
         if (mode == 1) begin
            enab = 1'b1; rw = 1'b0; Addr = 8'h06; data_in = 8'($urandom);
         end else begin
            enab = 1'($urandom); rw = 1'($urandom); Addr = 8'($urandom); data_in = 8'($urandom);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         enab = 1'b0; rw = 1'($urandom); Addr = 8'($urandom); data_in = 8'($urandom);
      end
   endtask

   // Reset pulse inside the low clock phase: no edge occurs while clr is low.
   task automatic reset_pulse();
      @(negedge clk);
      enab = 1'b0; e1 = 1'b0;
      #2 clr = 1'b0;
      #1;
      chk("rst_data_out", 64'(data_out), 64'h0);
      chk("rst_ack", 64'(ack), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_err", 64'(err), 64'h0);
      chk("rst_mem", {m0[7], m0[6], m0[5], m0[4], m0[3], m0[2], m0[1], m0[0]}, 64'h0);
      model_reset();
      #1 clr = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      #1;
      chk("init_data_out", 64'(data_out), 64'h0);
      chk("init_busy", 64'(busy), 64'h0);
      chk("init_ack", 64'(ack), 64'h0);
      chk("init_mem", {m0[7], m0[6], m0[5], m0[4], m0[3], m0[2], m0[1], m0[0]}, 64'h0);
      #11 clr = 1'b1;

      // LAT=1 instance: ack one edge after accept, enab during RESP not accepted.
      @(negedge clk);
      e1 = 1'b1; rw1 = 1'b1; a1 = 8'h02; d1 = 8'h5A;
      @(negedge clk);
      chk("l1_wait_ack", 64'(ack1), 64'h0);
      chk("l1_wait_busy", 64'(busy1), 64'h1);
      rw1 = 1'b0;
      @(negedge clk);
      chk("l1_resp_ack", 64'(ack1), 64'h1);
      chk("l1_mem2", 64'(m1[2]), 64'h5A);
      chk("l1_err", 64'(err1), 64'h0);
      @(negedge clk);
      chk("l1_idle_ack", 64'(ack1), 64'h0);
      chk("l1_idle_busy", 64'(busy1), 64'h0);
      @(negedge clk);
      chk("l1_rd_busy", 64'(busy1), 64'h1);
      chk("l1_rd_noack", 64'(ack1), 64'h0);
      @(negedge clk);
      chk("l1_rd_ack", 64'(ack1), 64'h1);
      chk("l1_rd_data", 64'(do1), 64'h5A);
      e1 = 1'b0;
      @(negedge clk);
      chk("l1_end_busy", 64'(busy1), 64'h0);

      // Write then read back-to-back, then held-enable reads of word 5.
      issue(1'b1, 8'h03, 8'hA5, 0);
      issue(1'b0, 8'h03, 8'h00, 0);
      issue(1'b1, 8'h05, 8'h5E, 0);
      issue(1'b1, 8'h06, 8'h6E, 0);
      issue(1'b0, 8'h05, 8'h00, 1);
      issue(1'b0, 8'h05, 8'h00, 1);
      issue(1'b0, 8'h05, 8'h00, 0);
      idle(2);

      reset_pulse();
      idle(1);

      // Abort a write in WAIT, then repeat it normally.
      @(negedge clk);
      enab = 1'b1; rw = 1'b1; Addr = 8'h07; data_in = 8'h3C;
      @(posedge clk);
      #1;
      model_issue(1'b1, 8'h07, 8'h3C, cyc);
      reset_pulse();
      issue(1'b1, 8'h07, 8'h3C, 0);
      issue(1'b0, 8'h07, 8'h00, 0);

      // Out-of-range address.
      issue(1'b1, 8'h13, 8'h77, 0);
      issue(1'b0, 8'h13, 8'h00, 0);
      issue(1'b0, 8'h03, 8'h00, 0);
      idle(1);

      for (int n = 0; n < 300; n++) begin
         logic [7:0] a;
         a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, DEPTH - 1));
         issue(1'($urandom_range(0, 2) != 0 ? 0 : 1) ^ 1'($urandom_range(0, 1)), a, 8'($urandom), 0);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end

      idle(LAT + 3);
      chk("scoreboard_drained", 64'(sb.size()), 64'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/ram_responder.md
# ram_responder

Backing-memory responder for the accumulator processor's cache. It is the RAM end of the cache-miss protocol: it accepts one read or write request at a time from the cache controller and holds it for a fixed, parameterised access latency. It then commits the write or returns the read data and signals completion with a one-cycle acknowledge. Words 0–7 are exported for bench and board monitoring, matching the cache's RAM monitor ports.

## Interface
- `d_width`, 8, data word width
- `a_width`, 8, request address width
- `DEPTH`, 16, number of stored words; power of two, 8 ≤ DEPTH ≤ 2^a_width
- `LAT`, 2, access latency in clocks, 1 ≤ LAT ≤ 15
- `clk` in 1: single clock; all state changes on posedge
- `clr` in 1: reset; asynchronous and active-low
- `enab` in 1: request valid; sampled only in IDLE
- `rw` in 1: 0 = read, 1 = write; sampled with `enab`
- `Addr` in a_width: target address; sampled with `enab`
- `data_in` in d_width: write data; sampled with `enab`
- `data_out` out d_width: read data; holds its value until the next read completes
- `ack` out 1: one-cycle completion pulse
- `busy` out 1: high whenever state ≠ IDLE
- `err` out 1: out-of-range flag, pulses with `ack` (see Configuration)
- `mem0`…`mem7` out d_width each: contents of words 0–7

## Operation
- States:
  - IDLE: if `enab` = 1, latch `rw`, `Addr` and `data_in`, load the counter with LAT−1, go to WAIT. Otherwise stay in IDLE.
  - WAIT: if counter = 0, go to RESP and perform the access. Otherwise decrement the counter.
  - RESP: go to IDLE unconditionally.
- The access happens on the WAIT→RESP edge:
  - Write: mem[idx] ← latched data. `data_out` is unchanged.
  - Read: `data_out` ← mem[idx].
  - Both: `ack` = 1 for the RESP cycle only.
- idx is the latched address reduced to its low log2(DEPTH) bits, unless out-of-range handling is enabled.
- Request fields are latched once. Changing or dropping `enab`, `rw`, `Addr` or `data_in` during WAIT or RESP has no effect on the request in flight.
- `enab` seen in WAIT or RESP is ignored, not queued. The requester keeps `enab` high until it sees `ack`. If `enab` is still high in the IDLE cycle after RESP, it is taken as a new request.
- No read-modify-write; at most one memory word changes per request.

## Timing
- Request accepted at edge t (state IDLE, `enab` = 1).
- `ack`, the read `data_out` and the write commit all become visible after edge t+LAT.
- `ack` drops after edge t+LAT+1.
- Back-to-back requests: minimum spacing between accepts is LAT+2 clocks.
- `busy` is high from after edge t through the RESP cycle.
- Reset (`clr` low, asynchronous, takes effect immediately):
  - state = IDLE, counter = 0
  - `ack` = 0, `err` = 0, `busy` = 0, `data_out` = 0
  - all DEPTH words = 0, so `mem0`…`mem7` read 0
- Reset during WAIT aborts the request: no write, no `ack`.
- Release of `clr` is synchronous in effect: the first accept can happen at the first posedge with `clr` = 1.

## Configuration
- `RAM_RESP_ERR_EN` defined:
  - A latched address ≥ DEPTH is out of range.
  - Out-of-range write: suppressed, memory unchanged.
  - Out-of-range read: `data_out` ← 0.
  - `err` = 1 together with `ack` in RESP; `err` = 0 at all other times.
  - Latency is unchanged.
- `RAM_RESP_ERR_EN` not defined:
  - The address wraps modulo DEPTH, so address 8'h13 with DEPTH = 16 accesses word 3.
  - `err` is tied to 0.

## Test plan
- **Reset contents:** Pulse `clr` low mid-cycle with no clock edge → `mem0`…`mem7` = 0, `data_out` = 0, `ack` = 0, `busy` = 0 immediately.
- **Write then read, LAT = 2:**
  - Write 8'hA5 to address 3 accepted at edge t → `ack` high only after edge t+2, `mem3` = 8'hA5 from the same edge, `busy` high for 3 cycles.
  - Read of address 3 accepted 4 edges after the write accept → `data_out` = 8'hA5 with `ack` at accept+2.
- **Held enable:** Keep `enab` = 1, `rw` = 0 on address 5 continuously → `ack` pulses every LAT+2 = 4 clocks. Change `Addr` to 6 during WAIT → the in-flight read still returns word 5.
- **Reset mid-operation:** Write 8'h3C to address 7, assert `clr` during WAIT → `mem7` = 0, no `ack`. The next request after release completes normally.
- **Out of range, DEPTH = 16:**
  - Write 8'h77 to address 8'h13.
  - With `RAM_RESP_ERR_EN`: memory unchanged, `err` = 1 with `ack`; a read of address 8'h13 gives `data_out` = 0 and `err` = 1.
  - Without `RAM_RESP_ERR_EN`: `mem3` = 8'h77 and `err` = 0.
- **LAT = 1 boundary:** Read accepted at edge t → `ack` after edge t+1. A request asserted during RESP is not accepted until the following IDLE cycle.
